// File: rtl/seq_divider_32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// single WIDTH+1-bit trial subtractor, with a start/busy/done handshake.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic             take;

    assign shifted = {rem_q, sreg_q[WIDTH-1]};
    assign {carry, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // diff[WIDTH] is always 0 when carry is set, so this equals carry alone.
    assign take = carry & ~diff[WIDTH];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B != '0) begin
                        sreg_d  = A;
                        dvs_d   = B;
                        rem_d   = '0;
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                rem_d  = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                sreg_d = {sreg_q[WIDTH-2:0], take};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    q_d     = sreg_d;
                    r_d     = rem_d;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_seq_divider_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Q;
    logic [31:0] R;
    logic        busy;
    logic        done;
    logic        DivZero;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          t;
        int          lat;
        int          bsy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reset checks, result/latency checks on done, timeout detection.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_Q", Q, 32'h0);
            chk("rst_R", R, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
            chk("rst_divzero", {31'h0, DivZero}, 32'h0);
            sb.delete();
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("Q", Q, e.q);
                    chk("R", R, e.r);
                    chk("DivZero", {31'h0, DivZero}, {31'h0, e.dz});
                    chk("latency", cyc - e.t, e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
                    chk("busy_during_done", {31'h0, busy}, 32'h0);
                end
                busy_cnt = 0;
            end else if (sb.size() != 0 && (cyc - sb[0].t) > sb[0].lat) begin
                e = sb.pop_front();
                chk("done_timeout", cyc - e.t, e.lat);
                busy_cnt = 0;
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        exp_t e;
        #1;
        A = a;
        B = b;
        start = 1'b1;
        e.q = eq;
        e.r = er;
        e.dz = edz;
        e.t = cyc;
        e.lat = (b == 0) ? 1 : 33;
        e.bsy = (b == 0) ? 0 : 32;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL wait_done: scoreboard still holds %0d entries after %0d cycles", sb.size(), n);
            $fatal(1, "bench stalled");
        end
    endtask

    task automatic div(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
        launch(a, b, eq, er, edz);
        wait_done();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          kind;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
        div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        div(32'd77, 32'd8, 32'd9, 32'd5, 1'b0);

        // Start pulse and operand change mid-RUN must be ignored.
        launch(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        A = 32'd1;
        B = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Reset during RUN aborts; first start after release is accepted.
        launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        div(32'd50, 32'd6, 32'd8, 32'd2, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            kind = $urandom_range(0, 3);
            case (kind)
                0: rb = 32'd1 << $urandom_range(0, 31);
                1: begin
                    ra = ra >> $urandom_range(1, 31);
                    rb = ra + 32'd1 + ($urandom & 32'hFF);
                    if (rb == 0) rb = 32'd1;
                end
                2: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 0) rb = 32'd3;
            div(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
